uart_tx: RTL and testbench

Serial UART transmitter that takes bytes from the FIFO summing controller (tx_data/tx_en) and drives the board TX pin. Frame format is 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1). A small internal byte FIFO absorbs bursts of tx_en pulses that arrive while a frame is in flight, so the controller never has to wait on the line rate. This block is the transmit end of the receive path that feeds rx_data/valid_flag.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 43 ++++
 rtl/uart_tx.sv | 121 ++++++++++++
 tb/tb_uart_tx.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Counter must hold 0..max-1; never narrower than one bit.
    function automatic int unsigned baud_cnt_w(input int unsigned max_cnt);
        return (max_cnt < 2) ? 1 : $clog2(max_cnt);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte write strobe and serial line status between controller and transmitter.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx;
    logic       tx_busy;
    logic       tx_overflow;

    modport master (output tx_data, tx_en, input tx, tx_busy, tx_overflow);
    modport slave  (input tx_data, tx_en, output tx, tx_busy, tx_overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; a push while full is accepted only if a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata_c,
    output logic       full_c,
    output logic       empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata_c = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || do_pop);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO absorbing write bursts.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic sys_clk,
    input  logic rst_n,
    uart_tx_if.slave bus
);
    localparam int unsigned BAUD_MAX = baud_cnt_max(CLK_FREQ, BAUD_RATE);
    localparam int unsigned BW       = baud_cnt_w(BAUD_MAX);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          pop_c;
    logic          push_ok_c;
    logic          baud_last_c;
    logic [7:0]    fifo_rdata_c;
    logic          fifo_full_c;
    logic          fifo_empty_c;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .push    (bus.tx_en),
        .wdata   (bus.tx_data),
        .pop     (pop_c),
        .rdata_c (fifo_rdata_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    assign baud_last_c = (baud_q == BW'(BAUD_MAX - 1));
    assign push_ok_c   = bus.tx_en && (!fifo_full_c || pop_c);

    // tx_d is the line value for the next cycle, so the pin is a plain flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_rdata_c;
                    bit_d   = 3'd0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || !fifo_empty_c || push_ok_c;
        ovf_d  = ovf_q || (bus.tx_en && fifo_full_c && !pop_c);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.tx          = tx_q;
    assign bus.tx_busy     = busy_q;
    assign bus.tx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: cycle-accurate timeline model, line decoder, directed and random cases.
module tb_uart_tx;
    localparam int BAUD  = 10;
    localparam int FRAME = 10 * BAUD;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_r = 1'b0;
    logic [7:0] data_r = 8'h00;

    uart_tx_if bus ();
    assign bus.tx_en   = en_r;
    assign bus.tx_data = data_r;

    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline model: each accepted byte has an accept cycle and a start-bit cycle.
    int         cyc = 0;
    int         m_drop = -1;
    int         m_acc[$];
    int         m_start[$];
    logic [7:0] m_byte[$];

    function automatic int occupancy(input int t);
        int n = 0;
        foreach (m_acc[k]) if (m_acc[k] < t && m_start[k] - 1 >= t) n++;
        return n;
    endfunction

    function automatic bit pop_at(input int t);
        foreach (m_start[k]) if (m_start[k] - 1 == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int next_start(input int t);
        if (m_start.size() > 0 && m_start[m_start.size()-1] + FRAME + 1 > t + 2)
            return m_start[m_start.size()-1] + FRAME + 1;
        return t + 2;
    endfunction

    function automatic logic exp_tx(input int t);
        int o;
        foreach (m_start[k]) begin
            if (t >= m_start[k] && t < m_start[k] + FRAME) begin
                o = (t - m_start[k]) / BAUD;
                if (o == 0) return 1'b0;
                if (o == 9) return 1'b1;
                return m_byte[k][o-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int t);
        foreach (m_acc[k]) if (t >= m_acc[k] + 1 && t <= m_start[k] + FRAME - 1) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_acc.delete();
            m_start.delete();
            m_byte.delete();
            m_drop <= -1;
        end else if (en_r) begin
            if (occupancy(cyc) < DEPTH || pop_at(cyc)) begin
                m_start.push_back(next_start(cyc));
                m_acc.push_back(cyc);
                m_byte.push_back(data_r);
            end else if (m_drop < 0) begin
                m_drop <= cyc;
            end
        end
        cyc <= cyc + 1;
    end

    // Line decoder sampling mid-bit; frames touched by reset are discarded.
    logic       dec_prev = 1'b1;
    logic       dec_ok = 1'b0;
    logic [7:0] dec_b = 8'h00;
    logic [8:0] rx_q[$];

    task automatic dec_wait(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!rst_n) dec_ok = 1'b0;
        end
    endtask

    always begin
        @(negedge clk);
        if (rst_n && dec_prev && !bus.tx) begin
            dec_ok = 1'b1;
            dec_wait(BAUD / 2);
            if (bus.tx !== 1'b0) dec_ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                dec_wait(BAUD);
                dec_b[i] = bus.tx;
            end
            dec_wait(BAUD);
            if (bus.tx !== 1'b1) dec_ok = 1'b0;
            if (dec_ok) rx_q.push_back({1'b1, dec_b});
        end
        dec_prev = bus.tx;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_model();
        if (!rst_n) begin
            chk("rst_tx", 32'(bus.tx), 32'd1);
            chk("rst_busy", 32'(bus.tx_busy), 32'd0);
            chk("rst_ovf", 32'(bus.tx_overflow), 32'd0);
        end else begin
            chk("tx", 32'(bus.tx), 32'(exp_tx(cyc)));
            chk("tx_busy", 32'(bus.tx_busy), 32'(exp_busy(cyc)));
            chk("tx_overflow", 32'(bus.tx_overflow), 32'(m_drop >= 0 && cyc > m_drop));
        end
    endtask

    task automatic tick(input logic en, input logic [7:0] d);
        @(negedge clk);
        check_model();
        en_r   = en;
        data_r = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'(($urandom)));
    endtask

    task automatic do_reset();
        tick(1'b0, 8'h00);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic chk_rx(input string name, input int base, input logic [7:0] exp[$]);
        chk({name, "_count"}, 32'(rx_q.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size() && base + i < rx_q.size(); i++)
            chk({name, "_byte"}, 32'(rx_q[base + i]), 32'({1'b1, exp[i]}));
    endtask

    typedef struct {
        int   off;
        logic exp_tx;
        logic exp_busy;
    } vec_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t       vecs[17];
        logic [7:0] exp_q[$];
        logic [7:0] sent[12];
        int         n0;
        int         base;

        vecs = '{'{1, 1, 1}, '{2, 0, 1}, '{11, 0, 1}, '{12, 1, 1}, '{21, 1, 1},
                 '{22, 0, 1}, '{32, 1, 1}, '{42, 0, 1}, '{52, 0, 1}, '{62, 1, 1},
                 '{72, 0, 1}, '{82, 1, 1}, '{91, 1, 1}, '{92, 1, 1}, '{101, 1, 1},
                 '{102, 1, 0}, '{105, 1, 0}};

        idle(3);
        rst_n = 1'b1;
        idle(5);

        // Single byte 0xA5 against fixed offsets from the strobe cycle.
        base = rx_q.size();
        tick(1'b1, 8'hA5);
        n0 = cyc;
        for (int c = 0; c < 110; c++) begin
            tick(1'b0, 8'h00);
            foreach (vecs[i]) begin
                if (vecs[i].off == cyc - n0) begin
                    chk("a5_tx", 32'(bus.tx), 32'(vecs[i].exp_tx));
                    chk("a5_busy", 32'(bus.tx_busy), 32'(vecs[i].exp_busy));
                end
            end
        end
        exp_q = '{8'hA5};
        chk_rx("a5", base, exp_q);

        // Burst of four back-to-back strobes.
        do_reset();
        base = rx_q.size();
        for (int i = 1; i <= 4; i++) tick(1'b1, 8'(i));
        idle(4 * (FRAME + 1) + 20);
        chk("burst_ovf", 32'(bus.tx_overflow), 32'd0);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        chk_rx("burst", base, exp_q);

        // Six strobes: one popped, four buffered, the sixth dropped.
        do_reset();
        base = rx_q.size();
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h10 + i));
        tick(1'b0, 8'h00);
        chk("ovf_set", 32'(bus.tx_overflow), 32'd1);
        idle(5 * (FRAME + 1) + 40);
        chk("ovf_sticky", 32'(bus.tx_overflow), 32'd1);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        chk_rx("drop", base, exp_q);

        // Push into a full FIFO in the very cycle the FSM pops.
        do_reset();
        base = rx_q.size();
        tick(1'b1, 8'hA0);
        n0 = cyc;
        for (int i = 1; i < 5; i++) tick(1'b1, 8'(8'hA0 + i));
        while (cyc < n0 + FRAME + 1) tick(1'b0, 8'h00);
        tick(1'b1, 8'hA5);
        chk("popfull_cycle", 32'(cyc - n0), 32'(FRAME + 2));
        idle(6 * (FRAME + 1) + 20);
        chk("popfull_ovf", 32'(bus.tx_overflow), 32'd0);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        chk_rx("popfull", base, exp_q);

        // Reset in the middle of a 0xFF data phase with two bytes queued.
        do_reset();
        base = rx_q.size();
        tick(1'b1, 8'hFF);
        n0 = cyc;
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        while (cyc < n0 + 2 + BAUD + 35) tick(1'b0, 8'h00);
        chk("mid_tx_high", 32'(bus.tx), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx", 32'(bus.tx), 32'd1);
        chk("abort_busy", 32'(bus.tx_busy), 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(3 * (FRAME + 1));
        chk("abort_busy_after", 32'(bus.tx_busy), 32'd0);
        exp_q.delete();
        chk_rx("abort", base, exp_q);

        // Twelve random bytes with gaps: pointers wrap, nothing lost.
        do_reset();
        base = rx_q.size();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            sent[i] = 8'($urandom);
            exp_q.push_back(sent[i]);
            tick(1'b1, sent[i]);
            idle($urandom_range(75, 120));
        end
        idle(5 * (FRAME + 1));
        chk("wrap_ovf", 32'(bus.tx_overflow), 32'd0);
        chk_rx("wrap", base, exp_q);

        // Random dense traffic against the timeline model, drops allowed.
        do_reset();
        base = rx_q.size();
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 8'($urandom));
            idle($urandom_range(0, 90));
        end
        idle(6 * (FRAME + 1));
        exp_q.delete();
        foreach (m_byte[k]) exp_q.push_back(m_byte[k]);
        chk_rx("rand", base, exp_q);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
